// File: rtl/lu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lu_pipe
// Purpose  : Two-stage pipelined bitwise logic unit with valid/ready flow
//            control, registered result and zero/parity flags.
//            Optional accumulate mode (macro LU_PIPE_ACC_EN) substitutes the
//            previous result for operand A on beats with acc=1.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            in_valid/in_ready - operand beat handshake (a, b, op, acc)
//            out_valid/out_ready - result handshake (y, zero, parity)
// Revision : 1.0 - initial release
// ============================================================================
module lu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity
);

    localparam logic [2:0] c_OP_AND  = 3'b000;
    localparam logic [2:0] c_OP_OR   = 3'b001;
    localparam logic [2:0] c_OP_XOR  = 3'b010;
    localparam logic [2:0] c_OP_ZERO = 3'b011;
    localparam logic [2:0] c_OP_NAND = 3'b100;
    localparam logic [2:0] c_OP_NOR  = 3'b101;
    localparam logic [2:0] c_OP_XNOR = 3'b110;
    localparam logic [2:0] c_OP_NOT  = 3'b111;

    // Stage 1 operand registers
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [2:0]       r_s1_op;

    // Stage 2 result registers
    logic             r_out_valid;
    logic [WIDTH-1:0] r_y;
    logic             r_zero;
    logic             r_parity;

    logic             w_s2_can_load;
    logic             w_s2_load;
    logic             w_accept;
    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_result;

    // in_ready depends only on pipeline state and out_ready, never on in_valid.
    assign w_s2_can_load = !r_out_valid || out_ready;
    assign w_s2_load     = r_s1_valid && w_s2_can_load;
    assign in_ready      = !r_s1_valid || w_s2_can_load;
    assign w_accept      = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Data fields need no reset; they are qualified by r_s1_valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_a  <= a;
            r_s1_b  <= b;
            r_s1_op <= op;
        end
    end

`ifdef LU_PIPE_ACC_EN
    logic             r_s1_acc;
    logic [WIDTH-1:0] r_acc;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_acc <= acc;
        end
    end

    // Tracks the most recent result so back-to-back accumulate beats chain
    // without a stall: the value is ready the same edge the result is.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_s2_load) begin
            r_acc <= w_result;
        end
    end

    assign w_x = r_s1_acc ? r_acc : r_s1_a;
`else
    logic w_unused_acc;
    assign w_unused_acc = acc;
    assign w_x          = r_s1_a;
`endif

    always_comb begin
        w_result = '0;
        case (r_s1_op)
            c_OP_AND:  w_result = w_x & r_s1_b;
            c_OP_OR:   w_result = w_x | r_s1_b;
            c_OP_XOR:  w_result = w_x ^ r_s1_b;
            c_OP_ZERO: w_result = '0;
            c_OP_NAND: w_result = ~(w_x & r_s1_b);
            c_OP_NOR:  w_result = ~(w_x | r_s1_b);
            c_OP_XNOR: w_result = ~(w_x ^ r_s1_b);
            c_OP_NOT:  w_result = ~w_x;
            default:   w_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_zero      <= 1'b1;
            r_parity    <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_y         <= w_result;
            r_zero      <= (w_result == '0);
            r_parity    <= ^w_result;
        end else if (w_s2_can_load) begin
            // Result consumed (or never present) and nothing new arriving.
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign zero      = r_zero;
    assign parity    = r_parity;

endmodule
`default_nettype wire

// File: tb/tb_lu_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_lu_pipe
// Purpose  : Self-checking bench for lu_pipe (WIDTH=8). Directed steps in one
//            initial block; a scoreboard queue holds expected results pushed
//            on input accept and popped on output handshake. Expected values
//            for accumulate follow LU_PIPE_ACC_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic       acc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       zero;
    logic       parity;

    lu_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc       (acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .parity    (parity)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_out = 0;
    logic [7:0] sb_q[$];
    logic [7:0] obs_q[$];
    logic [7:0] m_acc = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] fa, input logic [7:0] fb,
                                         input logic [2:0] fop, input logic facc,
                                         input logic [7:0] macc);
        logic [7:0] x;
`ifdef LU_PIPE_ACC_EN
        x = facc ? macc : fa;
`else
        x = fa;
        if (facc && 1'b0) x = macc;
`endif
        case (fop)
            3'd0: return x & fb;
            3'd1: return x | fb;
            3'd2: return x ^ fb;
            3'd3: return 8'h00;
            3'd4: return ~(x & fb);
            3'd5: return ~(x | fb);
            3'd6: return ~(x ^ fb);
            default: return ~x;
        endcase
    endfunction

    // Scoreboard: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) begin
            sb_q.delete();
            m_acc = 8'h00;
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("out_without_input", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("y", {24'd0, y}, {24'd0, e});
                    check("zero", {31'd0, zero}, {31'd0, (e == 8'h00)});
                    check("parity", {31'd0, parity}, {31'd0, ^e});
                    obs_q.push_back(y);
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                e = model(a, b, op, acc, m_acc);
                m_acc = e;
                sb_q.push_back(e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb_q.size() != 0; i++) step();
        check("drain_empty", sb_q.size(), 32'd0);
    endtask

    task automatic beat(input logic [7:0] fa, input logic [7:0] fb,
                        input logic [2:0] fop, input logic facc);
        in_valid = 1'b1;
        a = fa; b = fb; op = fop; acc = facc;
    endtask

    initial begin
        int         base;
        logic [7:0] exp0, exp1, exp2;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; acc = 1'b0;
        out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_y", {24'd0, y}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_parity", {31'd0, parity}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single beat: F0 ^ 3C = CC, latency two edges, one-cycle valid pulse
        beat(8'hF0, 8'h3C, 3'b010, 1'b0);
        step();
        in_valid = 1'b0;
        check("lat_edge1_valid", {31'd0, out_valid}, 32'd0);
        step();
        check("lat_edge2_valid", {31'd0, out_valid}, 32'd1);
        check("single_y", {24'd0, y}, 32'hCC);
        step();
        check("pulse_end_valid", {31'd0, out_valid}, 32'd0);

        // Op sweep at full rate
        obs_q.delete();
        for (int k = 0; k < 8; k++) begin
            beat(8'hA5, 8'h0F, k[2:0], 1'b0);
            check("sweep_in_ready", {31'd0, in_ready}, 32'd1);
            step();
        end
        in_valid = 1'b0;
        drain();
        check("sweep_count", obs_q.size(), 32'd8);
        if (obs_q.size() == 8) begin
            check("sweep_and",  {24'd0, obs_q[0]}, 32'h05);
            check("sweep_zero", {24'd0, obs_q[3]}, 32'h00);
            check("sweep_not",  {24'd0, obs_q[7]}, 32'h5A);
        end

        // Backpressure: two beats fill the pipe, third waits
        base = n_out;
        out_ready = 1'b0;
        beat(8'h11, 8'hFF, 3'b000, 1'b0); step();
        beat(8'h22, 8'hFF, 3'b000, 1'b0); step();
        beat(8'h33, 8'hFF, 3'b000, 1'b0);
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        step();
        check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_y", {24'd0, y}, 32'h11);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        drain();
        check("bp_delivered", n_out - base, 32'd3);

        // Accumulate chain, back-to-back
        obs_q.delete();
        beat(8'hFF, 8'h0F, 3'b000, 1'b0); step();
        beat(8'hFF, 8'h01, 3'b010, 1'b1); step();
        beat(8'hFF, 8'h02, 3'b010, 1'b1); step();
        in_valid = 1'b0; acc = 1'b0;
        drain();
`ifdef LU_PIPE_ACC_EN
        exp0 = 8'h0F; exp1 = 8'h0E; exp2 = 8'h0C;
`else
        exp0 = 8'h0F; exp1 = 8'hFE; exp2 = 8'hFD;
`endif
        check("acc_count", obs_q.size(), 32'd3);
        if (obs_q.size() == 3) begin
            check("acc_y0", {24'd0, obs_q[0]}, {24'd0, exp0});
            check("acc_y1", {24'd0, obs_q[1]}, {24'd0, exp1});
            check("acc_y2", {24'd0, obs_q[2]}, {24'd0, exp2});
        end

        // Reset with S1 and S2 both occupied
        out_ready = 1'b0;
        beat(8'h12, 8'h34, 3'b001, 1'b0); step();
        beat(8'h56, 8'h78, 3'b001, 1'b0); step();
        check("pre_rst_full", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_y", {24'd0, y}, 32'd0);
        check("mid_rst_zero", {31'd0, zero}, 32'd1);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_output", {31'd0, out_valid}, 32'd0);
        end
        obs_q.delete();
        beat(8'hC0, 8'h33, 3'b001, 1'b1); step();
        in_valid = 1'b0; acc = 1'b0;
        drain();
`ifdef LU_PIPE_ACC_EN
        exp0 = 8'h33;
`else
        exp0 = 8'hF3;
`endif
        check("post_rst_acc_count", obs_q.size(), 32'd1);
        if (obs_q.size() == 1) check("post_rst_acc_y", {24'd0, obs_q[0]}, {24'd0, exp0});

        // Random beats with random backpressure; scoreboard checks order/values
        base = n_out;
        for (int i = 0; i < 40; i++) begin
            out_ready = $urandom_range(0, 3) != 0;
            if (!in_valid || in_ready) begin
                beat($urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 7), $urandom_range(0, 1));
                in_valid = $urandom_range(0, 3) != 0;
            end
            #1;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        drain();
        check("rand_no_leftover_valid", {31'd0, out_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
